// File: rtl/reg_file_if.sv
// reg_file_if: S-bus write/read and ALU read signals of the register file
interface reg_file_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [DATA_WIDTH-1:0] sbus_in;
   logic [ADDR_WIDTH-1:0] write_select;
   logic [ADDR_WIDTH-1:0] sbus_select;
   logic [ADDR_WIDTH-1:0] alu_select;
   logic [DATA_WIDTH-1:0] sbus_out;
   logic [DATA_WIDTH-1:0] alu_out;
   modport master (
      output sbus_in, write_select, sbus_select, alu_select,
      input  sbus_out, alu_out
   );
   modport slave (
      input  sbus_in, write_select, sbus_select, alu_select,
      output sbus_out, alu_out
   );
endinterface

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, one S-bus write port, S-bus and ALU async read ports, r0 reads zero
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input logic          clk,
   input logic          rst_n,
   reg_file_if.slave    bus
);
   localparam int N = 2 ** ADDR_WIDTH;
   // r0 has no storage; index 0 never reaches the array
   logic [DATA_WIDTH-1:0] regs [1:N-1];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 1; i < N; i++) regs[i] <= '0;
      end else if (bus.write_select != '0) begin
         regs[bus.write_select] <= bus.sbus_in;
      end
   end
   always_comb begin
      bus.sbus_out = (bus.sbus_select == '0) ? '0 : regs[bus.sbus_select];
      bus.alu_out  = (bus.alu_select  == '0) ? '0 : regs[bus.alu_select];
   end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed checks of reset, write/readback, r0, dual read, no bypass, reset priority
module tb_reg_file;
   logic clk = 1'b0;
   logic rst_n;
   int checks = 0;
   int errors = 0;
   logic [31:0] v [32];

   reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
   reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [4:0] s, input logic [4:0] a);
      bus.sbus_select = s;
      bus.alu_select = a;
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus.write_select = a;
      bus.sbus_in = d;
      @(posedge clk);
      #1;
      bus.write_select = '0;
      bus.sbus_in = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.sbus_in = 32'hA5A5_A5A5;
      bus.write_select = 5'd3;
      bus.sbus_select = '0;
      bus.alu_select = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.write_select = '0;
      bus.sbus_in = '0;
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(31 - i));
         chk($sformatf("reset_sbus[%0d]", i), bus.sbus_out, 32'h0);
         chk($sformatf("reset_alu[%0d]", 31 - i), bus.alu_out, 32'h0);
      end

      v[0] = '0;
      for (int i = 1; i < 32; i++) begin
         v[i] = $urandom;
         wr(5'(i), v[i]);
      end
      for (int i = 1; i < 32; i++) begin
         rd(5'(i), 5'(32 - i));
         chk($sformatf("wr_sbus[%0d]", i), bus.sbus_out, v[i]);
         chk($sformatf("wr_alu[%0d]", 32 - i), bus.alu_out, v[32 - i]);
      end
      rd(5'd1, 5'd2);
      chk("no_cross_r1", bus.sbus_out, v[1]);
      chk("no_cross_r2", bus.alu_out, v[2]);

      wr(5'd0, 32'hDEAD_BEEF);
      rd(5'd0, 5'd0);
      chk("r0_sbus", bus.sbus_out, 32'h0);
      chk("r0_alu", bus.alu_out, 32'h0);
      for (int i = 1; i < 32; i++) begin
         rd(5'(i), 5'(i));
         chk($sformatf("r0_keep_sbus[%0d]", i), bus.sbus_out, v[i]);
         chk($sformatf("r0_keep_alu[%0d]", i), bus.alu_out, v[i]);
      end

      wr(5'd5, 32'h1234_5678);
      wr(5'd9, 32'hCAFE_F00D);
      rd(5'd5, 5'd9);
      chk("dual_sbus_r5", bus.sbus_out, 32'h1234_5678);
      chk("dual_alu_r9", bus.alu_out, 32'hCAFE_F00D);
      rd(5'd5, 5'd5);
      chk("same_sel_alu_r5", bus.alu_out, 32'h1234_5678);
      bus.write_select = 5'd5;
      bus.sbus_in = 32'h0BAD_0BAD;
      #1;
      chk("no_bypass_sbus", bus.sbus_out, 32'h1234_5678);
      chk("no_bypass_alu", bus.alu_out, 32'h1234_5678);
      @(posedge clk);
      #1;
      bus.write_select = '0;
      bus.sbus_in = '0;
      #1;
      chk("after_edge_sbus", bus.sbus_out, 32'h0BAD_0BAD);
      chk("after_edge_alu", bus.alu_out, 32'h0BAD_0BAD);

      wr(5'd7, 32'hFFFF_FFFF);
      rd(5'd7, 5'd9);
      chk("r7_set", bus.sbus_out, 32'hFFFF_FFFF);
      rst_n = 1'b0;
      wr(5'd7, 32'h1357_9BDF);
      rst_n = 1'b1;
      rd(5'd7, 5'd9);
      chk("rst_prio_r7", bus.sbus_out, 32'h0);
      chk("rst_clr_r9", bus.alu_out, 32'h0);
      rd(5'd5, 5'd31);
      chk("rst_clr_r5", bus.sbus_out, 32'h0);
      chk("rst_clr_r31", bus.alu_out, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
